// File: rtl/fifo_wr_packer_if.sv
// Beat-in / word-out bus for fifo_wr_packer. The master modport is the packer
// itself; the slave modport is the upstream source plus the downstream FIFO.
interface fifo_wr_packer_if #(
  parameter int InW  = 8,
  parameter int OutW = 32
);
  localparam int Ratio = OutW / InW;
  localparam int CntW  = $clog2(Ratio + 1);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [InW-1:0]  in_data_i;
  logic            in_last_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OutW-1:0] out_data_o;
  logic [CntW-1:0] out_cnt_o;
  logic            out_last_o;

  modport master (
    input  in_valid_i, in_data_i, in_last_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o
  );

  modport slave (
    output in_valid_i, in_data_i, in_last_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_last_o
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs InW-bit beats into OutW-bit words with lane count and last flag.
// Define FIFO_WR_PACKER_MSB_FIRST_EN to fill lanes MSB first instead of LSB first.
module fifo_wr_packer #(
  parameter int InW     = 8,
  parameter int OutW    = 32,
  parameter int Timeout = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_wr_packer_if.master  bus
);
  localparam int Ratio = OutW / InW;
  localparam int CntW  = $clog2(Ratio + 1);
  localparam int TmoW  = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [OutW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OutW-1:0] out_data_q, out_data_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            advance;
  logic            close;
  logic            tmo_fire;
  logic [OutW-1:0] word;
  logic [CntW-1:0] word_cnt;

  // In HOLD the input is only taken when the held word leaves in the same cycle.
  assign advance        = (state_q == FILL) | bus.out_ready_i;
  assign bus.in_ready_o = advance;
  assign accept         = bus.in_valid_i & advance;

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_cnt_o   = out_cnt_q;
  assign bus.out_last_o  = out_last_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    word     = (state_q == HOLD) ? '0 : acc_q;
    word_cnt = (state_q == HOLD) ? '0 : cnt_q;
    if (accept) begin
      for (int k = 0; k < Ratio; k++) begin
        if (word_cnt == CntW'(k)) begin
`ifdef FIFO_WR_PACKER_MSB_FIRST_EN
          word[OutW-(k+1)*InW +: InW] = bus.in_data_i;
`else
          word[k*InW +: InW] = bus.in_data_i;
`endif
        end
      end
      word_cnt = word_cnt + 1'b1;
    end

    close = (accept & ((word_cnt == CntW'(Ratio)) | bus.in_last_i))
          | (bus.flush_i & (word_cnt != '0))
          | tmo_fire;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (advance) begin
      if (close) begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_cnt_d   = word_cnt;
        out_last_d  = accept & bus.in_last_i;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        state_d     = FILL;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_cnt_d   = '0;
        out_last_d  = 1'b0;
        acc_d       = word;
        cnt_d       = word_cnt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  if (Timeout > 0) begin : g_tmo
    logic [TmoW-1:0] tmo_q;
    logic            idle;
    logic            tmo_inc;

    assign idle     = (state_q == FILL) & (cnt_q != '0) & ~accept;
    assign tmo_fire = idle & (tmo_q == TmoW'(Timeout - 1));
    assign tmo_inc  = idle & ~close;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        tmo_q <= '0;
      end else if (tmo_inc) begin
        tmo_q <= tmo_q + TmoW'(1);
      end else begin
        tmo_q <= '0;
      end
    end
  end else begin : g_no_tmo
    assign tmo_fire = 1'b0;
  end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed self-checking bench for fifo_wr_packer; expected words follow the
// lane order selected by FIFO_WR_PACKER_MSB_FIRST_EN.
module tb_fifo_wr_packer;
  localparam int InW     = 8;
  localparam int OutW    = 32;
  localparam int Timeout = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_packer_if #(.InW(InW), .OutW(OutW)) bus ();

  fifo_wr_packer #(.InW(InW), .OutW(OutW), .Timeout(Timeout)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] exp_word(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input int n);
    logic [7:0]  b [4];
    logic [31:0] w;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    w = '0;
    for (int k = 0; k < n; k++) begin
`ifdef FIFO_WR_PACKER_MSB_FIRST_EN
      w[OutW-(k+1)*InW +: InW] = b[k];
`else
      w[k*InW +: InW] = b[k];
`endif
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_last_i  = last;
    step();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_last_i = 1'b0;
    bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.in_ready_o); end
    checks++; if (bus.out_data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.out_data_o); end
    checks++; if (bus.out_cnt_o !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.out_cnt_o); end
    checks++; if (bus.out_last_o !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", bus.out_last_o); end
  endtask

  task automatic test_pack_four();
    logic [31:0] exp;
    exp = exp_word(8'h11, 8'h22, 8'h33, 8'h44, 4);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL four_early got %b exp 0", bus.out_valid_o); end
    send(8'h44, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL four_valid got %b exp 1", bus.out_valid_o); end
    checks++; if (bus.out_data_o !== exp) begin errors++; $display("FAIL four_data got %h exp %h", bus.out_data_o, exp); end
    checks++; if (bus.out_cnt_o !== 3'd4) begin errors++; $display("FAIL four_cnt got %0d exp 4", bus.out_cnt_o); end
    checks++; if (bus.out_last_o !== 1'b0) begin errors++; $display("FAIL four_last got %b exp 0", bus.out_last_o); end
    step();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL four_drain got %b exp 0", bus.out_valid_o); end
  endtask

  task automatic test_last();
    logic [31:0] exp;
    exp = exp_word(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL last_valid got %b exp 1", bus.out_valid_o); end
    checks++; if (bus.out_data_o !== exp) begin errors++; $display("FAIL last_data got %h exp %h", bus.out_data_o, exp); end
    checks++; if (bus.out_cnt_o !== 3'd2) begin errors++; $display("FAIL last_cnt got %0d exp 2", bus.out_cnt_o); end
    checks++; if (bus.out_last_o !== 1'b1) begin errors++; $display("FAIL last_flag got %b exp 1", bus.out_last_o); end
    send(8'hCC, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL last_next_fill got %b exp 0", bus.out_valid_o); end
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    exp = exp_word(8'hCC, 8'h00, 8'h00, 8'h00, 1);
    checks++; if (bus.out_data_o !== exp) begin errors++; $display("FAIL last_lane0 got %h exp %h", bus.out_data_o, exp); end
    checks++; if (bus.out_last_o !== 1'b0) begin errors++; $display("FAIL last_lane0_flag got %b exp 0", bus.out_last_o); end
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    int lat;
    exp = exp_word(8'h5A, 8'h00, 8'h00, 8'h00, 1);
    lat = -1;
    send(8'h5A, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.out_valid_o === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != Timeout) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", lat, Timeout); end
    checks++; if (bus.out_data_o !== exp) begin errors++; $display("FAIL tmo_data got %h exp %h", bus.out_data_o, exp); end
    checks++; if (bus.out_cnt_o !== 3'd1) begin errors++; $display("FAIL tmo_cnt got %0d exp 1", bus.out_cnt_o); end
    step();
  endtask

  task automatic test_hold_stall();
    logic [31:0] exp;
    exp = exp_word(8'h01, 8'h02, 8'h03, 8'h04, 4);
    bus.out_ready_i = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'h77;
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", bus.in_ready_o); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp || bus.in_ready_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b d=%h r=%b exp v=1 d=%h r=0", i, bus.out_valid_o, bus.out_data_o, bus.in_ready_o, exp);
      end
    end
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", bus.in_ready_o); end
    step();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL stall_refill got %b exp 0", bus.out_valid_o); end
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    exp = exp_word(8'h77, 8'h00, 8'h00, 8'h00, 1);
    checks++; if (bus.out_data_o !== exp || bus.out_cnt_o !== 3'd1) begin
      errors++; $display("FAIL stall_lane0 got d=%h c=%0d exp d=%h c=1", bus.out_data_o, bus.out_cnt_o, exp);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] exp;
    exp = exp_word(8'h10, 8'h99, 8'h00, 8'h00, 2);
    bus.flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty%0d got %b exp 0", i, bus.out_valid_o); end
    end
    bus.flush_i = 1'b0;
    send(8'h10, 1'b0);
    bus.flush_i = 1'b1;
    send(8'h99, 1'b0);
    bus.flush_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", bus.out_valid_o); end
    checks++; if (bus.out_data_o !== exp) begin errors++; $display("FAIL flush_data got %h exp %h", bus.out_data_o, exp); end
    checks++; if (bus.out_cnt_o !== 3'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", bus.out_cnt_o); end
    checks++; if (bus.out_last_o !== 1'b0) begin errors++; $display("FAIL flush_last got %b exp 0", bus.out_last_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b;
    exp_a = exp_word(8'h21, 8'h22, 8'h23, 8'h24, 4);
    exp_b = exp_word(8'h25, 8'h26, 8'h27, 8'h28, 4);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'h21 + 8'(k);
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", k, bus.in_ready_o); end
      step();
      if (k == 3 || k == 7) begin
        checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== ((k == 3) ? exp_a : exp_b)) begin
          errors++; $display("FAIL b2b_word%0d got v=%b d=%h exp v=1 d=%h", k, bus.out_valid_o, bus.out_data_o, (k == 3) ? exp_a : exp_b);
        end
      end else begin
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got %b exp 0", k, bus.out_valid_o); end
      end
    end
    bus.in_valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    exp = exp_word(8'hB1, 8'hB2, 8'hB3, 8'hB4, 4);
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_outs got v=%b r=%b exp v=0 r=1", bus.out_valid_o, bus.in_ready_o);
    end
    step();
    rst = 1'b0;
    send(8'hB1, 1'b0); send(8'hB2, 1'b0); send(8'hB3, 1'b0); send(8'hB4, 1'b0);
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp || bus.out_cnt_o !== 3'd4) begin
      errors++; $display("FAIL rstmid_word got v=%b d=%h c=%0d exp v=1 d=%h c=4", bus.out_valid_o, bus.out_data_o, bus.out_cnt_o, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_pack_four();
    test_last();
    test_timeout();
    test_hold_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
